sevenseg_scan_ctrl: RTL and testbench

//  Time-multiplexing scheduler for the board's 4-digit common-anode seven-segment display.

---
 rtl/sevenseg_wr_if.sv | 28 ++
 rtl/sevenseg_scan_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_wr_if.sv
// Write port carrying new display content from the CPU side into the
// seven-segment scan controller (valid/ready handshake).
interface sevenseg_wr_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_value;
    logic [3:0]  wr_dp;
    logic [3:0]  wr_blank;
    logic [3:0]  wr_bright;

    modport master (
        output wr_valid,
        output wr_value,
        output wr_dp,
        output wr_blank,
        output wr_bright,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_value,
        input  wr_dp,
        input  wr_blank,
        input  wr_bright,
        output wr_ready
    );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan of a 4-digit common-anode seven-segment display with
// guard gaps, PWM brightness and frame-aligned commit of new content.
module sevenseg_scan_ctrl #(
    parameter int SLOT_CYCLES  = 100000,
    parameter int GUARD_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    sevenseg_wr_if.slave     wr,
    output logic [6:0]       seg,
    output logic             dp,
    output logic [3:0]       an,
    output logic             frame_tick
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD_CYCLES);

    typedef enum logic [0:0] {
        ST_OFF  = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [1:0]       idx_r;
    logic [1:0]       idx_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [3:0]       pwm_r;
    logic [3:0]       pwm_nxt_s;

    logic [15:0]      pend_value_r;
    logic [3:0]       pend_dp_r;
    logic [3:0]       pend_blank_r;
    logic [3:0]       pend_bright_r;
    logic             pending_r;

    logic [15:0]      act_value_r;
    logic [3:0]       act_dp_r;
    logic [3:0]       act_blank_r;
    logic [3:0]       act_bright_r;

    logic             in_scan_s;
    logic             frame_end_s;
    logic             wr_fire_s;
    logic             commit_s;
    logic             lit_s;

    logic [6:0]       seg_nxt_s;
    logic             dp_nxt_s;
    logic [3:0]       an_nxt_s;
    logic [6:0]       seg_r;
    logic             dp_r;
    logic [3:0]       an_r;
    logic             frame_tick_r;

    // Active-low gfedcba glyphs for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign in_scan_s   = (state_r == ST_SCAN) && enable;
    assign frame_end_s = in_scan_s && (idx_r == 2'd3) && (cnt_r == CNT_LAST);
    assign wr_fire_s   = wr.wr_valid && !pending_r;
    // Content swaps at the frame boundary, or at once while the display is dark.
    assign commit_s    = pending_r && (frame_end_s || !enable);
    assign wr.wr_ready = ~pending_r;

    // Scan state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_OFF;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: enable alone moves between OFF and SCAN.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_OFF: begin
                if (enable) state_nxt_s = ST_SCAN;
                else        state_nxt_s = ST_OFF;
            end
            ST_SCAN: begin
                if (!enable) state_nxt_s = ST_OFF;
                else         state_nxt_s = ST_SCAN;
            end
            default: state_nxt_s = ST_OFF;
        endcase
    end

    // Slot / digit / PWM counter next values; everything parks at zero outside SCAN.
    always_comb begin
        idx_nxt_s = 2'd0;
        cnt_nxt_s = '0;
        pwm_nxt_s = 4'd0;
        if (in_scan_s) begin
            if (cnt_r == CNT_LAST) begin
                cnt_nxt_s = '0;
                idx_nxt_s = idx_r + 2'd1;
            end else begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
                idx_nxt_s = idx_r;
            end
            if (cnt_r < GUARD_C) pwm_nxt_s = 4'd0;
            else                 pwm_nxt_s = pwm_r + 4'd1;
        end else begin
            idx_nxt_s = 2'd0;
            cnt_nxt_s = '0;
            pwm_nxt_s = 4'd0;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= 2'd0;
            cnt_r <= '0;
            pwm_r <= 4'd0;
        end else begin
            idx_r <= idx_nxt_s;
            cnt_r <= cnt_nxt_s;
            pwm_r <= pwm_nxt_s;
        end
    end

    // Pending and active content registers with frame-aligned commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_value_r  <= 16'h0000;
            pend_dp_r     <= 4'h0;
            pend_blank_r  <= 4'hF;
            pend_bright_r <= 4'hF;
            pending_r     <= 1'b0;
            act_value_r   <= 16'h0000;
            act_dp_r      <= 4'h0;
            act_blank_r   <= 4'hF;
            act_bright_r  <= 4'hF;
        end else begin
            if (wr_fire_s) begin
                pend_value_r  <= wr.wr_value;
                pend_dp_r     <= wr.wr_dp;
                pend_blank_r  <= wr.wr_blank;
                pend_bright_r <= wr.wr_bright;
                pending_r     <= 1'b1;
            end else if (commit_s) begin
                act_value_r   <= pend_value_r;
                act_dp_r      <= pend_dp_r;
                act_blank_r   <= pend_blank_r;
                act_bright_r  <= pend_bright_r;
                pending_r     <= 1'b0;
            end else begin
                pending_r     <= pending_r;
            end
        end
    end

    assign lit_s = (cnt_r >= GUARD_C) && (pwm_r < act_bright_r) && !act_blank_r[idx_r];

    // Output decode: seg/dp follow the digit through the whole slot, an gates visibility.
    always_comb begin
        seg_nxt_s = 7'h7F;
        dp_nxt_s  = 1'b1;
        an_nxt_s  = 4'hF;
        if (in_scan_s) begin
            seg_nxt_s = hex_to_seg(act_value_r[{idx_r, 2'b00} +: 4]);
            dp_nxt_s  = ~act_dp_r[idx_r];
            if (lit_s) an_nxt_s = ~(4'b0001 << idx_r);
            else       an_nxt_s = 4'hF;
        end else begin
            seg_nxt_s = 7'h7F;
            dp_nxt_s  = 1'b1;
            an_nxt_s  = 4'hF;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r        <= 7'h7F;
            dp_r         <= 1'b1;
            an_r         <= 4'hF;
            frame_tick_r <= 1'b0;
        end else begin
            seg_r        <= seg_nxt_s;
            dp_r         <= dp_nxt_s;
            an_r         <= an_nxt_s;
            frame_tick_r <= frame_end_s;
        end
    end

    assign seg        = seg_r;
    assign dp         = dp_r;
    assign an         = an_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench for sevenseg_scan_ctrl: per-cycle expected display words are
// queued from a reference of the scan timing and compared against the outputs.
module tb_sevenseg_scan_ctrl;

    localparam int SLOT  = 34;
    localparam int GUARD = 2;
    localparam int FRAME = 4 * SLOT;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dpm;
        logic [3:0]  blank;
        logic [3:0]  bright;
    } cfg_t;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       enable = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_tick;

    int n_checks = 0;
    int n_errors = 0;
    logic [12:0] exp_q[$];
    logic [12:0] dark_w = {1'b0, 4'hF, 1'b1, 7'h7F};

    sevenseg_wr_if wr_bus();

    sevenseg_scan_ctrl #(
        .SLOT_CYCLES (SLOT),
        .GUARD_CYCLES(GUARD)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .wr        (wr_bus),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tbl[n];
    endfunction

    // Expected {frame_tick, an, dp, seg} p cycles after the previous frame_tick sample.
    function automatic logic [12:0] expect_at(input cfg_t c, input int p);
        int         d = p / SLOT;
        int         k = p % SLOT;
        logic [3:0] a = 4'hF;
        logic [3:0] nib = c.value[4*d +: 4];
        if (k >= GUARD) begin
            int pw = (k - GUARD) % 16;
            if (pw < int'(c.bright) && !c.blank[d]) a[d] = 1'b0;
        end
        return {(p == FRAME - 1), a, ~c.dpm[d], glyph(nib)};
    endfunction

    task automatic show(input cfg_t c, input int first, input int last, output int lit);
        logic [12:0] e;
        lit = 0;
        for (int p = first; p <= last; p++) exp_q.push_back(expect_at(c, p));
        for (int p = first; p <= last; p++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check_eq($sformatf("scan p=%0d", p), {19'd0, frame_tick, an, dp, seg}, {19'd0, e});
            if (an != 4'hF) lit++;
        end
    endtask

    task automatic write_cfg(input cfg_t c);
        wr_bus.wr_value  = c.value;
        wr_bus.wr_dp     = c.dpm;
        wr_bus.wr_blank  = c.blank;
        wr_bus.wr_bright = c.bright;
        wr_bus.wr_valid  = 1'b1;
    endtask

    task automatic check_dark(input string tag);
        check_eq(tag, {19'd0, frame_tick, an, dp, seg}, {19'd0, dark_w});
    endtask

    // Reset between clock edges, then release with enable=1 and land on p=-1 of a frame.
    task automatic reset_pulse();
        #3 rst_n = 1'b0;
        #1;
        check_dark("reset outputs");
        check_eq("reset wr_ready", {31'd0, wr_bus.wr_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_dark("post-reset off cycle");
    endtask

    // Write issued at a frame-end sample: old content for one more frame, then new.
    task automatic write_and_show(input cfg_t old_c, input cfg_t new_c, output int lit);
        int d;
        check_eq("wr_ready idle", {31'd0, wr_bus.wr_ready}, 32'd1);
        write_cfg(new_c);
        show(old_c, 0, 0, d);
        check_eq("wr_ready after accept", {31'd0, wr_bus.wr_ready}, 32'd0);
        wr_bus.wr_valid = 1'b0;
        show(old_c, 1, FRAME - 1, d);
        check_eq("wr_ready after commit", {31'd0, wr_bus.wr_ready}, 32'd1);
        show(new_c, 0, FRAME - 1, lit);
    endtask

    initial begin
        cfg_t rst_c  = {16'h0000, 4'b0000, 4'b1111, 4'hF};
        cfg_t c1234  = {16'h1234, 4'b0001, 4'b0000, 4'hF};
        cfg_t cabcd  = {16'hABCD, 4'b1010, 4'b0000, 4'hF};
        cfg_t c0f89  = {16'h0F89, 4'b0100, 4'b0000, 4'hF};
        cfg_t cb0    = {16'h1234, 4'b0000, 4'b0000, 4'h0};
        cfg_t cb8    = {16'h5E67, 4'b0011, 4'b0000, 4'h8};
        cfg_t cbl    = {16'h4321, 4'b1000, 4'b1000, 4'hF};
        cfg_t c9876  = {16'h9876, 4'b0010, 4'b0000, 4'hF};
        int   lit;
        int   d;

        wr_bus.wr_valid  = 1'b0;
        wr_bus.wr_value  = 16'h0000;
        wr_bus.wr_dp     = 4'h0;
        wr_bus.wr_blank  = 4'h0;
        wr_bus.wr_bright = 4'h0;
        enable = 1'b1;

        reset_pulse();
        show(rst_c, 0, FRAME - 1, lit);
        check_eq("dark after reset", lit, 32'd0);

        write_and_show(rst_c, c1234, lit);
        check_eq("lit 1234", lit, 32'd120);

        // Mid-frame write must not tear; a second write stalls until the commit.
        show(c1234, 0, 40, d);
        check_eq("wr_ready mid-frame", {31'd0, wr_bus.wr_ready}, 32'd1);
        write_cfg(cabcd);
        show(c1234, 41, 41, d);
        check_eq("wr_ready stall", {31'd0, wr_bus.wr_ready}, 32'd0);
        wr_bus.wr_valid = 1'b0;
        show(c1234, 42, 59, d);
        write_cfg(c0f89);
        show(c1234, 60, 100, d);
        check_eq("second write stalled", {31'd0, wr_bus.wr_ready}, 32'd0);
        show(c1234, 101, FRAME - 1, d);
        check_eq("ready at commit", {31'd0, wr_bus.wr_ready}, 32'd1);
        show(cabcd, 0, 0, d);
        check_eq("held write accepted", {31'd0, wr_bus.wr_ready}, 32'd0);
        wr_bus.wr_valid = 1'b0;
        show(cabcd, 1, FRAME - 1, lit);
        check_eq("lit abcd", lit, 32'd120);
        check_eq("single accept", {31'd0, wr_bus.wr_ready}, 32'd1);
        show(c0f89, 0, FRAME - 1, lit);
        check_eq("lit 0f89", lit, 32'd120);

        write_and_show(c0f89, cb0, lit);
        check_eq("lit bright0", lit, 32'd0);
        write_and_show(cb0, cb8, lit);
        check_eq("lit bright8", lit, 32'd64);
        write_and_show(cb8, cbl, lit);
        check_eq("lit blank3", lit, 32'd90);

        // Disable during digit 2 with a write pending.
        write_cfg(c9876);
        show(cbl, 0, 0, d);
        check_eq("pending before disable", {31'd0, wr_bus.wr_ready}, 32'd0);
        wr_bus.wr_valid = 1'b0;
        show(cbl, 1, 78, d);
        enable = 1'b0;
        @(negedge clk);
        check_dark("disable dark");
        check_eq("commit on disable", {31'd0, wr_bus.wr_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_dark("held dark");
        end
        enable = 1'b1;
        @(negedge clk);
        check_dark("restart off cycle");
        show(c9876, 0, FRAME - 1, lit);
        check_eq("lit 9876", lit, 32'd120);

        show(c9876, 0, 49, d);
        reset_pulse();
        show(rst_c, 0, FRAME - 1, lit);
        check_eq("dark after mid-lit reset", lit, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
